cache_fill_fsm: RTL and testbench

Memory-side fill engine for the 2-way-free, direct-mapped 128-line, 16-byte-block cache.
- Accepts a miss from the cache controller.
- Issues eight sequential word reads to pipelined main memory.
- Streams the returned words into the data array, then writes the tag array.
- Holds the processor stalled until the fill completes.

---
 rtl/cache_pkg.sv | 41 ++++
 rtl/fill_word_counter.sv | 37 +++
 rtl/cache_fill_fsm.sv | 119 +++++++++++
 tb/tb_cache_fill_fsm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types, geometry constants and address field helpers for the
// direct-mapped 128-line, 16-byte-block cache fill path.
package cache_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int BLOCK_BYTES = 16;
  localparam int WORDS       = 8;
  localparam int INDEX_W     = 7;
  localparam int TAG_W       = 5;
  localparam int OFFSET_W    = 4;
  localparam int MEM_LAT     = 4;
  localparam int CNT_W       = 4;
  localparam int WSEL_W      = 3;

  localparam logic [CNT_W-1:0] WORDS_CNT = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Saturating 0..WORDS word counter used to track issued requests and
// consumed responses of one block fill.
module fill_word_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == WORDS_CNT);
  assign cnt  = cnt_q;

  // Clear wins over increment; once at WORDS the count holds.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Block fill engine: issues eight pipelined word reads for a missing line,
// streams the returned words into the data array, then writes the tag.
//
// state | meaning
// IDLE  | waiting for a miss; accepts it combinationally (busy in accept cycle)
// FILL  | issuing word reads and writing returned words into the data array
// DONE  | one-cycle tag array write for the filled line
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_detected,
  input  logic [ADDR_W-1:0]   miss_address,
  output logic                fsm_busy,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_data_valid,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                write_data_array,
  output logic [WSEL_W-1:0]   word_sel,
  output logic [DATA_W-1:0]   data_out,
  output logic                write_tag_array,
  output logic [INDEX_W-1:0]  index_out,
  output logic [TAG_W-1:0]    tag_out
);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              accept;
  logic [CNT_W-1:0]  req_cnt, rsp_cnt;
  logic              req_done, rsp_done;

  fill_word_counter u_req_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (accept),
    .inc   (mem_en),
    .cnt   (req_cnt),
    .done  (req_done)
  );

  fill_word_counter u_rsp_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (accept),
    .inc   (write_data_array),
    .cnt   (rsp_cnt),
    .done  (rsp_done)
  );

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    accept           = 1'b0;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    word_sel         = '0;
    data_out         = '0;
    write_tag_array  = 1'b0;
    index_out        = '0;
    tag_out          = '0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          accept   = 1'b1;
          fsm_busy = 1'b1;
          base_d   = block_base(miss_address);
          state_d  = FILL;
        end
      end

      FILL: begin
        fsm_busy  = 1'b1;
        index_out = addr_index(base_q);
        tag_out   = addr_tag(base_q);
        // Requests and responses are independent and may coincide.
        if (!req_done) begin
          mem_en   = 1'b1;
          mem_addr = base_q + ADDR_W'({req_cnt, 1'b0});
        end
        if (mem_data_valid && !rsp_done) begin
          write_data_array = 1'b1;
          word_sel         = rsp_cnt[WSEL_W-1:0];
          data_out         = mem_data;
          if (rsp_cnt == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        index_out       = addr_index(base_q);
        tag_out         = addr_tag(base_q);
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency memory model and
// scoreboard queues for read addresses, data-array writes and tag writes.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data;
  logic        write_data_array;
  logic [2:0]  word_sel;
  logic [15:0] data_out;
  logic        write_tag_array;
  logic [6:0]  index_out;
  logic [4:0]  tag_out;

  cache_fill_fsm dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .fsm_busy         (fsm_busy),
    .mem_en           (mem_en),
    .mem_addr         (mem_addr),
    .mem_data_valid   (mem_data_valid),
    .mem_data         (mem_data),
    .write_data_array (write_data_array),
    .word_sel         (word_sel),
    .data_out         (data_out),
    .write_tag_array  (write_tag_array),
    .index_out        (index_out),
    .tag_out          (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Timeline model: k is the cycle number relative to the accept cycle.
  bit          active = 1'b0;
  int          k = 0;
  int          rsp_model = 0;
  logic [15:0] mbase = '0;

  logic [15:0] q_addr[$];
  logic [18:0] q_wr[$];
  logic [11:0] q_tag[$];

  logic        resp_v[16];
  logic [15:0] resp_d[16];

  int tag_count = 0;
  int last_tag_cyc = 0;
  int prev_tag_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    active = 1'b0;
    k = 0;
    rsp_model = 0;
    q_addr.delete();
    q_wr.delete();
    q_tag.delete();
    for (int i = 0; i < 16; i++) begin
      resp_v[i] = 1'b0;
      resp_d[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    miss_detected  = 1'b0;
    mem_data_valid = 1'b0;
    mem_data       = '0;
    rst = 1'b0;
    #1;
    chk("rst_busy",      32'(fsm_busy), 32'd0);
    chk("rst_mem_en",    32'(mem_en), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_wr_data",   32'(write_data_array), 32'd0);
    chk("rst_word_sel",  32'(word_sel), 32'd0);
    chk("rst_data_out",  32'(data_out), 32'd0);
    chk("rst_wr_tag",    32'(write_tag_array), 32'd0);
    chk("rst_index",     32'(index_out), 32'd0);
    chk("rst_tag",       32'(tag_out), 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input logic miss, input logic [15:0] addr, input logic stray);
    int          slot;
    logic        exp_wr;
    logic        exp_en;
    logic        exp_tag;
    logic [18:0] w;
    logic [11:0] t;
    @(posedge clk);
    #1;
    cyc++;
    slot = cyc % 16;
    if (active && k == 14) active = 1'b0;
    miss_detected = miss;
    miss_address  = addr;
    exp_wr = 1'b0;
    if (resp_v[slot]) begin
      mem_data_valid = 1'b1;
      mem_data       = resp_d[slot];
      resp_v[slot]   = 1'b0;
      if (active && rsp_model < 8) begin
        q_wr.push_back({3'(rsp_model), resp_d[slot]});
        rsp_model++;
        exp_wr = 1'b1;
      end
    end else if (stray) begin
      mem_data_valid = 1'b1;
      mem_data       = 16'hDEAD;
    end else begin
      mem_data_valid = 1'b0;
      mem_data       = 16'($urandom);
    end
    if (!active && miss) begin
      active    = 1'b1;
      k         = 0;
      rsp_model = 0;
      mbase     = {addr[15:4], 4'h0};
      for (int i = 0; i < 8; i++) q_addr.push_back(mbase + 16'(2 * i));
      q_tag.push_back({mbase[15:11], mbase[10:4]});
    end
    #1;
    exp_en  = active && k >= 1 && k <= 8;
    exp_tag = active && k == 13;
    chk("busy",   32'(fsm_busy), 32'(active));
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    if (mem_en) begin
      chk("addr_q_nonempty", 32'(q_addr.size() != 0), 32'd1);
      if (q_addr.size() != 0) chk("mem_addr", 32'(mem_addr), 32'(q_addr.pop_front()));
    end
    chk("wr_data_strobe", 32'(write_data_array), 32'(exp_wr));
    if (write_data_array) begin
      chk("wr_q_nonempty", 32'(q_wr.size() != 0), 32'd1);
      if (q_wr.size() != 0) begin
        w = q_wr.pop_front();
        chk("word_sel", 32'(word_sel), 32'(w[18:16]));
        chk("data_out", 32'(data_out), 32'(w[15:0]));
      end
    end
    chk("wr_tag_strobe", 32'(write_tag_array), 32'(exp_tag));
    if (write_tag_array) begin
      tag_count++;
      prev_tag_cyc = last_tag_cyc;
      last_tag_cyc = cyc;
      chk("tag_q_nonempty", 32'(q_tag.size() != 0), 32'd1);
      if (q_tag.size() != 0) begin
        t = q_tag.pop_front();
        chk("tag_out_at_write",   32'(tag_out), 32'(t[11:7]));
        chk("index_out_at_write", 32'(index_out), 32'(t[6:0]));
      end
    end
    chk("index_out", 32'(index_out), active && k >= 1 ? 32'(mbase[10:4]) : 32'd0);
    chk("tag_out",   32'(tag_out),   active && k >= 1 ? 32'(mbase[15:11]) : 32'd0);
    // Memory model: data 0xA000 + word offset, returned MEM_LAT cycles later.
    if (mem_en) begin
      resp_v[(cyc + 4) % 16] = 1'b1;
      resp_d[(cyc + 4) % 16] = 16'hA000 + 16'(mem_addr[3:1]);
    end
    if (active) k++;
  endtask

  initial begin
    int tags_before;
    int first_tag;
    rst            = 1'b1;
    miss_detected  = 1'b0;
    miss_address   = '0;
    mem_data_valid = 1'b0;
    mem_data       = '0;
    clear_model();

    // Reset then idle with stray valids.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'($urandom_range(0, 1)));

    // Basic fill to 0x1A36: tag 0x03, index 0x23.
    tags_before = tag_count;
    step(1'b1, 16'h1A36, 1'b0);
    repeat (14) step(1'b0, 16'h0, 1'b0);
    chk("basic_one_tag", 32'(tag_count - tags_before), 32'd1);
    chk("basic_tag_val", 32'(mbase[15:11]), 32'h03);
    chk("basic_idx_val", 32'(mbase[10:4]), 32'h23);
    chk("basic_scoreboard_empty", 32'(q_addr.size() + q_wr.size() + q_tag.size()), 32'd0);

    // Miss held through the fill, address changes mid-fill; re-accepted at k=14.
    tags_before = tag_count;
    repeat (6) step(1'b1, 16'h1A36, 1'b0);
    repeat (22) step(1'b1, 16'hFFF2, 1'b0);
    repeat (3) step(1'b0, 16'h0, 1'b0);
    chk("held_two_tags", 32'(tag_count - tags_before), 32'd2);
    chk("held_second_base", 32'(mbase), 32'hFFF0);

    // Reset aborts a fill at cycle 9: no tag write for it.
    step(1'b1, 16'h3C48, 1'b0);
    repeat (8) step(1'b0, 16'h0, 1'b0);
    tags_before = tag_count;
    do_reset();
    repeat (20) step(1'b0, 16'h0, 1'b0);
    chk("abort_no_tag", 32'(tag_count), 32'(tags_before));
    step(1'b1, 16'h0000, 1'b0);
    repeat (14) step(1'b0, 16'h0, 1'b0);
    chk("after_abort_tag", 32'(tag_count - tags_before), 32'd1);

    // Stray valids in DONE and IDLE.
    tags_before = tag_count;
    step(1'b1, 16'h2460, 1'b0);
    repeat (12) step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    repeat (4) step(1'b0, 16'h0, 1'b1);
    chk("stray_one_tag", 32'(tag_count - tags_before), 32'd1);

    // Back-to-back misses with continuous request.
    tags_before = tag_count;
    repeat (14) step(1'b1, 16'h0454, 1'b0);
    first_tag = last_tag_cyc;
    repeat (14) step(1'b1, 16'h8A2C, 1'b0);
    repeat (3) step(1'b0, 16'h0, 1'b0);
    chk("b2b_two_tags", 32'(tag_count - tags_before), 32'd2);
    chk("b2b_spacing", 32'(last_tag_cyc - first_tag), 32'd14);
    chk("b2b_scoreboard_empty", 32'(q_addr.size() + q_wr.size() + q_tag.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
